// File: rtl/uart_link_pkg.sv
// Shared opcode, sync-payload and state types for the game-link UART frame decoder.
package uart_link_pkg;

  typedef enum logic [2:0] {
    OP_SYNC    = 3'b000,
    OP_KEEP_LO = 3'b001,
    OP_KEEP_HI = 3'b010,
    OP_X_LO    = 3'b011,
    OP_X_HI    = 3'b100,
    OP_Y_LO    = 3'b101,
    OP_Y_HI    = 3'b110,
    OP_SCORE   = 3'b111
  } opcode_e;

  localparam logic [4:0] SYNC_SHOOT_START = 5'b11001;
  localparam logic [4:0] SYNC_START       = 5'b01001;
  localparam logic [4:0] SYNC_IDLE        = 5'b00001;
  localparam logic [4:0] SYNC_BACK        = 5'b00101;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } state_e;

  // Position inside the x_lo -> x_hi -> y_lo -> y_hi shot sequence.
  typedef enum logic [1:0] {
    SEQ_NONE = 2'd0,
    SEQ_X_LO = 2'd1,
    SEQ_X_HI = 2'd2,
    SEQ_Y_LO = 2'd3
  } shot_seq_e;

  function automatic logic is_valid_sync(input logic [4:0] p);
    return (p == SYNC_SHOOT_START) || (p == SYNC_START) ||
           (p == SYNC_IDLE) || (p == SYNC_BACK);
  endfunction

endpackage

// File: rtl/uart_link_watchdog.sv
// Link watchdog: saturating cycle counter cleared by a valid sync; flags expiry
// for one cycle when the limit is reached while the link is up. TIMEOUT_CYCLES=0 disables it.
module uart_link_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 6_500_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sync_clr,
  input  logic armed,
  output logic expire
);

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_off
      assign expire = 1'b0;
    end else begin : g_on
      localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
      localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);
      localparam logic [CW-1:0] LAST  = CW'(TIMEOUT_CYCLES - 1);

      logic [CW-1:0] cnt_q, cnt_d;

      always_comb begin
        cnt_d = cnt_q;
        if (sync_clr) begin
          cnt_d = '0;
        end else if (cnt_q != LIMIT) begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      // A sync arriving on the expiry cycle wins, so the link is never dropped then.
      assign expire = (cnt_q == LAST) && armed && !sync_clr;
    end
  endgenerate

endmodule

// File: rtl/uart_frame_decoder.sv
// Pops bytes from the UART RX FIFO and decodes sync/keeper/shot/score fragments.
// Optional counters frag_err_cnt / bytes_cnt exist only with UART_FRAME_DECODER_STATS_EN.
//   state   | meaning
//   ST_IDLE | waiting for a byte at the FIFO head; decodes and pops it
//   ST_ACK  | rd_uart high for the pop; head is ignored
module uart_frame_decoder
  import uart_link_pkg::*;
#(
  parameter int unsigned FIELD_BITS     = 10,
  parameter int unsigned TIMEOUT_CYCLES = 6_500_000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            read_data,
  input  logic                  rx_empty,
  output logic                  rd_uart,
  output logic                  connect_ok,
  output logic                  enemy_shooter,
  output logic                  game_starts,
  output logic                  back_to_start,
  output logic [FIELD_BITS-1:0] keeper_pos,
  output logic                  keeper_vld,
  output logic [FIELD_BITS-1:0] x_shooter,
  output logic [FIELD_BITS-1:0] y_shooter,
  output logic                  shot_vld,
  output logic [2:0]            opponent_score,
  output logic                  enemy_is_scored,
  output logic                  enemy_input,
  output logic                  score_vld,
  output logic                  link_lost
`ifdef UART_FRAME_DECODER_STATS_EN
  ,
  output logic [7:0]            frag_err_cnt,
  output logic [15:0]           bytes_cnt
`endif
);

  state_e    state_q, state_d;
  shot_seq_e shot_seq_q, shot_seq_d;

  logic rd_q, rd_d;
  logic conn_q, conn_d, shooter_q, shooter_d, starts_q, starts_d, back_q, back_d;
  logic [4:0] keep_lo_q, keep_lo_d;
  logic keep_pend_q, keep_pend_d;
  logic [FIELD_BITS-1:0] keeper_pos_q, keeper_pos_d;
  logic keeper_vld_q, keeper_vld_d;
  logic [4:0] x_lo_q, x_lo_d, x_hi_q, x_hi_d, y_lo_q, y_lo_d;
  logic [FIELD_BITS-1:0] x_q, x_d, y_q, y_d;
  logic shot_vld_q, shot_vld_d;
  logic [2:0] score_q, score_d;
  logic scored_q, scored_d, input_q, input_d, score_vld_q, score_vld_d;
  logic link_lost_q, link_lost_d;

  opcode_e    op;
  logic [4:0] pay;
  logic [9:0] keep_full, x_full, y_full;
  logic       consume, sync_ok, expire, frag_err;

  assign op        = opcode_e'(read_data[2:0]);
  assign pay       = read_data[7:3];
  assign keep_full = {pay, keep_lo_q};
  assign x_full    = {x_hi_q, x_lo_q};
  assign y_full    = {pay, y_lo_q};
  assign consume   = (state_q == ST_IDLE) && !rx_empty;
  assign sync_ok   = consume && (op == OP_SYNC) && is_valid_sync(pay);

  uart_link_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .sync_clr(sync_ok),
    .armed   (conn_q),
    .expire  (expire)
  );

  always_comb begin
    state_d      = state_q;
    shot_seq_d   = shot_seq_q;
    rd_d         = 1'b0;
    conn_d       = conn_q;
    shooter_d    = shooter_q;
    starts_d     = starts_q;
    back_d       = back_q;
    keep_lo_d    = keep_lo_q;
    keep_pend_d  = keep_pend_q;
    keeper_pos_d = keeper_pos_q;
    keeper_vld_d = 1'b0;
    x_lo_d       = x_lo_q;
    x_hi_d       = x_hi_q;
    y_lo_d       = y_lo_q;
    x_d          = x_q;
    y_d          = y_q;
    shot_vld_d   = 1'b0;
    score_d      = score_q;
    scored_d     = scored_q;
    input_d      = input_q;
    score_vld_d  = 1'b0;
    link_lost_d  = 1'b0;
    frag_err     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (consume) begin
          rd_d    = 1'b1;
          state_d = ST_ACK;
          case (op)
            OP_SYNC: begin
              if (sync_ok) begin
                conn_d    = 1'b1;
                shooter_d = pay[4];
                starts_d  = pay[3];
                back_d    = pay[2];
              end else begin
                conn_d    = 1'b0;
                shooter_d = 1'b0;
                starts_d  = 1'b0;
                back_d    = 1'b0;
                frag_err  = 1'b1;
              end
            end
            OP_KEEP_LO: begin
              keep_lo_d   = pay;
              keep_pend_d = 1'b1;
            end
            OP_KEEP_HI: begin
              if (keep_pend_q) begin
                keeper_pos_d = keep_full[FIELD_BITS-1:0];
                keeper_vld_d = 1'b1;
                keep_pend_d  = 1'b0;
              end else begin
                frag_err = 1'b1;
              end
            end
            OP_X_LO: begin
              x_lo_d     = pay;
              shot_seq_d = SEQ_X_LO;
            end
            OP_X_HI: begin
              if (shot_seq_q == SEQ_X_LO) begin
                x_hi_d     = pay;
                shot_seq_d = SEQ_X_HI;
              end else begin
                shot_seq_d = SEQ_NONE;
                frag_err   = 1'b1;
              end
            end
            OP_Y_LO: begin
              if (shot_seq_q == SEQ_X_HI) begin
                y_lo_d     = pay;
                shot_seq_d = SEQ_Y_LO;
              end else begin
                shot_seq_d = SEQ_NONE;
                frag_err   = 1'b1;
              end
            end
            OP_Y_HI: begin
              if (shot_seq_q == SEQ_Y_LO) begin
                x_d        = x_full[FIELD_BITS-1:0];
                y_d        = y_full[FIELD_BITS-1:0];
                shot_vld_d = 1'b1;
              end else begin
                frag_err = 1'b1;
              end
              shot_seq_d = SEQ_NONE;
            end
            OP_SCORE: begin
              score_d     = pay[2:0];
              scored_d    = pay[3];
              input_d     = pay[4];
              score_vld_d = 1'b1;
            end
          endcase
        end
      end
      ST_ACK: state_d = ST_IDLE;
    endcase

    if (expire) begin
      conn_d      = 1'b0;
      shooter_d   = 1'b0;
      starts_d    = 1'b0;
      back_d      = 1'b0;
      link_lost_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      shot_seq_q   <= SEQ_NONE;
      rd_q         <= 1'b0;
      conn_q       <= 1'b0;
      shooter_q    <= 1'b0;
      starts_q     <= 1'b0;
      back_q       <= 1'b0;
      keep_lo_q    <= '0;
      keep_pend_q  <= 1'b0;
      keeper_pos_q <= '0;
      keeper_vld_q <= 1'b0;
      x_lo_q       <= '0;
      x_hi_q       <= '0;
      y_lo_q       <= '0;
      x_q          <= '0;
      y_q          <= '0;
      shot_vld_q   <= 1'b0;
      score_q      <= '0;
      scored_q     <= 1'b0;
      input_q      <= 1'b0;
      score_vld_q  <= 1'b0;
      link_lost_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      shot_seq_q   <= shot_seq_d;
      rd_q         <= rd_d;
      conn_q       <= conn_d;
      shooter_q    <= shooter_d;
      starts_q     <= starts_d;
      back_q       <= back_d;
      keep_lo_q    <= keep_lo_d;
      keep_pend_q  <= keep_pend_d;
      keeper_pos_q <= keeper_pos_d;
      keeper_vld_q <= keeper_vld_d;
      x_lo_q       <= x_lo_d;
      x_hi_q       <= x_hi_d;
      y_lo_q       <= y_lo_d;
      x_q          <= x_d;
      y_q          <= y_d;
      shot_vld_q   <= shot_vld_d;
      score_q      <= score_d;
      scored_q     <= scored_d;
      input_q      <= input_d;
      score_vld_q  <= score_vld_d;
      link_lost_q  <= link_lost_d;
    end
  end

  assign rd_uart         = rd_q;
  assign connect_ok      = conn_q;
  assign enemy_shooter   = shooter_q;
  assign game_starts     = starts_q;
  assign back_to_start   = back_q;
  assign keeper_pos      = keeper_pos_q;
  assign keeper_vld      = keeper_vld_q;
  assign x_shooter       = x_q;
  assign y_shooter       = y_q;
  assign shot_vld        = shot_vld_q;
  assign opponent_score  = score_q;
  assign enemy_is_scored = scored_q;
  assign enemy_input     = input_q;
  assign score_vld       = score_vld_q;
  assign link_lost       = link_lost_q;

`ifdef UART_FRAME_DECODER_STATS_EN
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic [15:0] bytes_q, bytes_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    bytes_d   = bytes_q;
    if (frag_err && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
    if (consume) bytes_d = bytes_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
      bytes_q   <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
      bytes_q   <= bytes_d;
    end
  end

  assign frag_err_cnt = err_cnt_q;
  assign bytes_cnt    = bytes_q;
`else
  logic unused_frag_err;
  assign unused_frag_err = frag_err;
`endif

endmodule

// File: tb/tb_uart_frame_decoder.sv
// Randomized bench for uart_frame_decoder against a cycle-level reference model;
// stats ports are checked when UART_FRAME_DECODER_STATS_EN is defined.
module tb_uart_frame_decoder;

  localparam int FB = 10;
  localparam int TO = 100;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [7:0] read_data = 8'h00;
  logic rx_empty = 1'b1;
  logic rd_uart, connect_ok, enemy_shooter, game_starts, back_to_start;
  logic [FB-1:0] keeper_pos, x_shooter, y_shooter;
  logic keeper_vld, shot_vld, score_vld, link_lost, enemy_is_scored, enemy_input;
  logic [2:0] opponent_score;
`ifdef UART_FRAME_DECODER_STATS_EN
  logic [7:0]  frag_err_cnt;
  logic [15:0] bytes_cnt;
`endif

  always #5 clk = ~clk;

  uart_frame_decoder #(.FIELD_BITS(FB), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .read_data(read_data), .rx_empty(rx_empty),
    .rd_uart(rd_uart), .connect_ok(connect_ok), .enemy_shooter(enemy_shooter),
    .game_starts(game_starts), .back_to_start(back_to_start),
    .keeper_pos(keeper_pos), .keeper_vld(keeper_vld),
    .x_shooter(x_shooter), .y_shooter(y_shooter), .shot_vld(shot_vld),
    .opponent_score(opponent_score), .enemy_is_scored(enemy_is_scored),
    .enemy_input(enemy_input), .score_vld(score_vld), .link_lost(link_lost)
`ifdef UART_FRAME_DECODER_STATS_EN
    , .frag_err_cnt(frag_err_cnt), .bytes_cnt(bytes_cnt)
`endif
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: values the outputs must hold after the upcoming edge.
  logic m_busy, m_rd, m_conn, m_es, m_gs, m_bts, m_ll;
  logic m_kpend, m_kv, m_sv, m_scv, m_scored, m_inp;
  logic [4:0] m_klo, m_xlo, m_xhi, m_ylo;
  logic [FB-1:0] m_kpos, m_xs, m_ys;
  logic [2:0] m_sc;
  int m_seq, m_wd, m_err;
  logic [15:0] m_bytes;

  logic [7:0] fifo[$];
  logic hold_empty = 1'b0;
  int n_rd = 0, n_kv = 0, n_sv = 0, n_scv = 0, n_ll = 0;

  function automatic logic valid_sync(input logic [4:0] p);
    return (p == 5'd25) || (p == 5'd9) || (p == 5'd1) || (p == 5'd5);
  endfunction

  task automatic model_reset();
    m_busy = 0; m_rd = 0; m_conn = 0; m_es = 0; m_gs = 0; m_bts = 0; m_ll = 0;
    m_kpend = 0; m_kv = 0; m_sv = 0; m_scv = 0; m_scored = 0; m_inp = 0;
    m_klo = 0; m_xlo = 0; m_xhi = 0; m_ylo = 0; m_kpos = 0; m_xs = 0; m_ys = 0;
    m_sc = 0; m_seq = 0; m_wd = 0; m_err = 0; m_bytes = 0;
  endtask

  task automatic bump_err();
    if (m_err < 255) m_err++;
  endtask

  task automatic model_step(input logic e, input logic [7:0] d);
    logic [4:0] p;
    logic [2:0] op;
    logic take, good_sync, expired;
    p = d[7:3];
    op = d[2:0];
    m_kv = 0; m_sv = 0; m_scv = 0; m_ll = 0;
    take = !m_busy && !e;
    m_rd = take;
    m_busy = take;
    good_sync = take && (op == 3'd0) && valid_sync(p);
    expired = (TO > 0) && (m_wd == TO - 1) && m_conn && !good_sync;
    if (good_sync) m_wd = 0;
    else if (m_wd < TO) m_wd++;
    if (take) begin
      m_bytes = m_bytes + 16'd1;
      case (op)
        3'd0: begin
          if (good_sync) begin
            m_conn = 1; m_es = p[4]; m_gs = p[3]; m_bts = p[2];
          end else begin
            m_conn = 0; m_es = 0; m_gs = 0; m_bts = 0; bump_err();
          end
        end
        3'd1: begin m_klo = p; m_kpend = 1; end
        3'd2: begin
          if (m_kpend) begin
            m_kpos = FB'((int'(p) * 32 + int'(m_klo)) % (1 << FB));
            m_kv = 1; m_kpend = 0;
          end else bump_err();
        end
        3'd3: begin m_xlo = p; m_seq = 1; end
        3'd4: begin
          if (m_seq == 1) begin m_xhi = p; m_seq = 2; end
          else begin m_seq = 0; bump_err(); end
        end
        3'd5: begin
          if (m_seq == 2) begin m_ylo = p; m_seq = 3; end
          else begin m_seq = 0; bump_err(); end
        end
        3'd6: begin
          if (m_seq == 3) begin
            m_xs = FB'((int'(m_xhi) * 32 + int'(m_xlo)) % (1 << FB));
            m_ys = FB'((int'(p) * 32 + int'(m_ylo)) % (1 << FB));
            m_sv = 1;
          end else bump_err();
          m_seq = 0;
        end
        default: begin m_sc = p[2:0]; m_scored = p[3]; m_inp = p[4]; m_scv = 1; end
      endcase
    end
    if (expired) begin
      m_conn = 0; m_es = 0; m_gs = 0; m_bts = 0; m_ll = 1;
    end
  endtask

  task automatic compare_all();
    check("rd_uart", rd_uart, m_rd);
    check("link", {connect_ok, enemy_shooter, game_starts, back_to_start, link_lost},
          {m_conn, m_es, m_gs, m_bts, m_ll});
    check("keeper", {keeper_vld, keeper_pos}, {m_kv, m_kpos});
    check("shot", {shot_vld, x_shooter, y_shooter}, {m_sv, m_xs, m_ys});
    check("score", {score_vld, enemy_input, enemy_is_scored, opponent_score},
          {m_scv, m_inp, m_scored, m_sc});
`ifdef UART_FRAME_DECODER_STATS_EN
    check("stats", {frag_err_cnt, bytes_cnt}, {8'(m_err), m_bytes});
`endif
  endtask

  task automatic tick();
    logic e;
    logic [7:0] d;
    if (m_rd) void'(fifo.pop_front());
    e = (fifo.size() == 0) || hold_empty;
    d = (fifo.size() != 0) ? fifo[0] : 8'($urandom);
    rx_empty = e;
    read_data = d;
    model_step(e, d);
    @(negedge clk);
    compare_all();
    if (rd_uart) n_rd++;
    if (keeper_vld) n_kv++;
    if (shot_vld) n_sv++;
    if (score_vld) n_scv++;
    if (link_lost) n_ll++;
  endtask

  task automatic drain();
    int g;
    g = 0;
    hold_empty = 0;
    while ((fifo.size() != 0 || m_busy) && g < 400) begin
      tick();
      g++;
    end
    if (g >= 400) check("drain_bound", fifo.size(), 0);
  endtask

  task automatic push_item();
    int k;
    logic [4:0] p;
    k = $urandom_range(0, 5);
    case (k)
      0: fifo.push_back(8'($urandom));
      1: begin
        case ($urandom_range(0, 3))
          0: p = 5'b11001;
          1: p = 5'b01001;
          2: p = 5'b00001;
          default: p = 5'b00101;
        endcase
        fifo.push_back({p, 3'd0});
      end
      2: begin
        fifo.push_back({5'($urandom), 3'd1});
        fifo.push_back({5'($urandom), 3'd2});
      end
      3: for (int op = 3; op <= 6; op++) fifo.push_back({5'($urandom), 3'(op)});
      4: fifo.push_back({5'($urandom), 3'd7});
      default: fifo.push_back({5'($urandom), 3'($urandom_range(4, 6))});
    endcase
  endtask

  initial begin
    int r0, k0, s0, c0, l0, g;
`ifdef UART_FRAME_DECODER_STATS_EN
    int e0;
`endif
    model_reset();
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    compare_all();
    check("reset_outs", {rd_uart, connect_ok, enemy_shooter, game_starts, back_to_start,
          keeper_pos, keeper_vld, x_shooter, y_shooter, shot_vld}, 0);
    rst_n = 1'b1;

    // sync 01001
    r0 = n_rd;
    fifo.push_back(8'h48);
    drain();
    check("tp1_rd_pulses", n_rd - r0, 1);
    check("tp1_link", {connect_ok, game_starts, enemy_shooter}, 3'b110);

    // keeper 10101 / 00001
    k0 = n_kv;
    fifo.push_back(8'hA9);
    fifo.push_back(8'h0A);
    drain();
    check("tp2_keeper_pos", keeper_pos, 10'h035);
    check("tp2_kv_pulses", n_kv - k0, 1);

    // full shot sequence
    s0 = n_sv;
    fifo.push_back(8'h1B); fifo.push_back(8'h0C); fifo.push_back(8'h2D); fifo.push_back(8'h06);
    drain();
    check("tp3_sv_pulses", n_sv - s0, 1);
    check("tp3_xy", {x_shooter, y_shooter}, {10'd35, 10'd5});

    // out-of-order shot bytes
    s0 = n_sv;
`ifdef UART_FRAME_DECODER_STATS_EN
    e0 = int'(frag_err_cnt);
`endif
    fifo.push_back(8'h0C); fifo.push_back(8'h06);
    drain();
    check("tp4_sv_pulses", n_sv - s0, 0);
    check("tp4_xy", {x_shooter, y_shooter}, {10'd35, 10'd5});
`ifdef UART_FRAME_DECODER_STATS_EN
    check("tp4_frag_err", int'(frag_err_cnt) - e0, 2);
`endif

    // score
    c0 = n_scv;
    fifo.push_back(8'h5F);
    drain();
    check("tp5_score", {enemy_input, enemy_is_scored, opponent_score}, 5'b01011);
    check("tp5_scv_pulses", n_scv - c0, 1);

    // reset between keeper fragments drops the low half
    k0 = n_kv;
    fifo.push_back(8'hA9);
    tick(); tick();
    rst_n = 1'b0;
    fifo.delete();
    model_reset();
    rx_empty = 1'b1;
    #1;
    compare_all();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    fifo.push_back(8'h0A);
    drain();
    check("midreset_kv_pulses", n_kv - k0, 0);

    // watchdog expiry after TO idle cycles
    fifo.push_back(8'h48);
    drain();
    l0 = n_ll;
    repeat (TO + 10) tick();
    check("wd_ll_pulses", n_ll - l0, 1);
    check("wd_connect_ok", connect_ok, 0);

    // sync landing exactly on the expiry cycle
    fifo.push_back(8'h48);
    drain();
    l0 = n_ll;
    g = 0;
    while (m_wd != TO - 1 && g < 3 * TO) begin
      tick();
      g++;
    end
    check("wd_reach_bound", g < 3 * TO, 1);
    fifo.push_back(8'h48);
    tick();
    tick();
    check("wd_sync_wins_ll", n_ll - l0, 0);
    check("wd_sync_wins_conn", connect_ok, 1);

    // random traffic
    for (int it = 0; it < 300; it++) begin
      push_item();
      repeat ($urandom_range(1, 8)) begin
        hold_empty = ($urandom_range(0, 3) == 0);
        tick();
      end
      if ($urandom_range(0, 19) == 0) begin
        hold_empty = 1;
        repeat (TO + 20) tick();
      end
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
